// File: rtl/vector_lsu_responder.sv
`timescale 1ns/1ps
// vector_lsu_responder
// Turns a held scalar/vector load-store request into a stream of single-word
// beats on a req/gnt memory port and collects in-order read returns.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   address             request word address (only [ADDR_W-1:0] used)
//   memWriteM/memtoRegW level-held write/read request (write has priority)
//   memSrcM             1 = 16-element vector, 0 = scalar
//   data_in/data_in_vec scalar / vector write data (element i at [16*i +: 16])
//   data_out/_vec       read results, held until the next read overwrites them
//   write_done/data_ready  one-cycle completion pulses
//   busy                high whenever the engine is not idle
//   mem_*               memory port: req/we/addr/wdata held until mem_gnt,
//                       rvalid/rdata returned in issue order
module vector_lsu_responder #(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       address,
    input  logic              memWriteM,
    input  logic              memtoRegW,
    input  logic              memSrcM,
    input  logic [15:0]       data_in,
    input  logic [255:0]      data_in_vec,
    output logic [15:0]       data_out,
    output logic [255:0]      data_out_vec,
    output logic              write_done,
    output logic              data_ready,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              vec_q, vec_d;
    logic              op_write_q, op_write_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [255:0]      wvec_q, wvec_d;
    logic [4:0]        issue_cnt_q, issue_cnt_d;
    logic [4:0]        resp_cnt_q, resp_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              write_done_q, write_done_d;
    logic              data_ready_q, data_ready_d;
    logic              busy_q, busy_d;
    logic [15:0]       data_out_q, data_out_d;
    logic [255:0]      data_out_vec_q, data_out_vec_d;

    logic [4:0]        n_beats_s;
    logic [4:0]        issue_next_s;
    logic [4:0]        resp_next_s;
    logic              unused_addr_s;

    // Upper address bits are architecturally ignored.
    assign unused_addr_s = ^address[31:ADDR_W];

    // Beat address wraps modulo 2^ADDR_W through the natural adder width.
    function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [4:0]        idx);
        return base + {{(ADDR_W-5){1'b0}}, idx};
    endfunction

    // Write data for beat idx: a vector element or the single scalar word.
    function automatic logic [15:0] beat_wdata(input logic         is_vec,
                                               input logic [15:0]  scalar,
                                               input logic [255:0] vec,
                                               input logic [3:0]   idx);
        logic [15:0] r;
        if (is_vec) begin
            r = vec[{idx, 4'b0000} +: 16];
        end else begin
            r = scalar;
        end
        return r;
    endfunction

    assign n_beats_s    = vec_q ? 5'd16 : 5'd1;
    assign issue_next_s = issue_cnt_q + 5'd1;
    assign resp_next_s  = resp_cnt_q + 5'd1;

    // Next-state, beat issue and read-return collection.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        vec_d          = vec_q;
        op_write_d     = op_write_q;
        wdata_d        = wdata_q;
        wvec_d         = wvec_q;
        issue_cnt_d    = issue_cnt_q;
        resp_cnt_d     = resp_cnt_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        write_done_d   = 1'b0;
        data_ready_d   = 1'b0;
        data_out_d     = data_out_q;
        data_out_vec_d = data_out_vec_q;

        case (state_q)
            ST_IDLE: begin
                if (memWriteM || memtoRegW) begin
                    // Snapshot the request; beat 0 is presented on the next cycle.
                    base_d      = address[ADDR_W-1:0];
                    vec_d       = memSrcM;
                    op_write_d  = memWriteM;
                    wdata_d     = data_in;
                    wvec_d      = data_in_vec;
                    issue_cnt_d = 5'd0;
                    resp_cnt_d  = 5'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = memWriteM;
                    mem_addr_d  = address[ADDR_W-1:0];
                    if (memWriteM) begin
                        mem_wdata_d = beat_wdata(memSrcM, data_in, data_in_vec, 4'd0);
                        state_d     = ST_WRITE;
                    end else begin
                        mem_wdata_d = 16'h0000;
                        state_d     = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                if (mem_gnt) begin
                    issue_cnt_d = issue_next_s;
                    if (issue_next_s == n_beats_s) begin
                        mem_req_d    = 1'b0;
                        mem_we_d     = 1'b0;
                        write_done_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        mem_addr_d  = beat_addr(base_q, issue_next_s);
                        mem_wdata_d = beat_wdata(vec_q, wdata_q, wvec_q, issue_next_s[3:0]);
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end

            ST_READ: begin
                // Issue side: stops requesting once all beats are granted.
                if (mem_req_q && mem_gnt) begin
                    issue_cnt_d = issue_next_s;
                    if (issue_next_s == n_beats_s) begin
                        mem_req_d = 1'b0;
                    end else begin
                        mem_addr_d = beat_addr(base_q, issue_next_s);
                    end
                end else begin
                    issue_cnt_d = issue_cnt_q;
                end
                // Return side: counted independently; surplus returns dropped.
                if (mem_rvalid && (resp_cnt_q < n_beats_s)) begin
                    resp_cnt_d = resp_next_s;
                    if (vec_q) begin
                        data_out_vec_d[{resp_cnt_q[3:0], 4'b0000} +: 16] = mem_rdata;
                        if (resp_cnt_q == 5'd0) begin
                            data_out_d = mem_rdata;
                        end else begin
                            data_out_d = data_out_q;
                        end
                    end else begin
                        data_out_d = mem_rdata;
                    end
                    if (resp_next_s == n_beats_s) begin
                        mem_req_d    = 1'b0;
                        mem_we_d     = 1'b0;
                        data_ready_d = 1'b1;
                        state_d      = ST_RESP;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    resp_cnt_d = resp_cnt_q;
                end
            end

            ST_RESP: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            base_q         <= {ADDR_W{1'b0}};
            vec_q          <= 1'b0;
            op_write_q     <= 1'b0;
            wdata_q        <= 16'h0000;
            wvec_q         <= 256'h0;
            issue_cnt_q    <= 5'd0;
            resp_cnt_q     <= 5'd0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= {ADDR_W{1'b0}};
            mem_wdata_q    <= 16'h0000;
            write_done_q   <= 1'b0;
            data_ready_q   <= 1'b0;
            busy_q         <= 1'b0;
            data_out_q     <= 16'h0000;
            data_out_vec_q <= 256'h0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            vec_q          <= vec_d;
            op_write_q     <= op_write_d;
            wdata_q        <= wdata_d;
            wvec_q         <= wvec_d;
            issue_cnt_q    <= issue_cnt_d;
            resp_cnt_q     <= resp_cnt_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            write_done_q   <= write_done_d;
            data_ready_q   <= data_ready_d;
            busy_q         <= busy_d;
            data_out_q     <= data_out_d;
            data_out_vec_q <= data_out_vec_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_out_vec = data_out_vec_q;
    assign write_done   = write_done_q;
    assign data_ready   = data_ready_q;
    assign busy         = busy_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_vector_lsu_responder.sv
`timescale 1ns/1ps
// Directed self-checking bench for vector_lsu_responder with a behavioural
// word memory (grant either tied high or random, read latency 2 cycles).
module tb_vector_lsu_responder;

    localparam int ADDR_W = 24;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       address = 32'h0;
    logic              memWriteM = 1'b0;
    logic              memtoRegW = 1'b0;
    logic              memSrcM = 1'b0;
    logic [15:0]       data_in = 16'h0;
    logic [255:0]      data_in_vec = 256'h0;
    logic [15:0]       data_out;
    logic [255:0]      data_out_vec;
    logic              write_done;
    logic              data_ready;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_gnt = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [15:0]       mem_rdata = 16'h0;

    always #5 clk = ~clk;

    vector_lsu_responder #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .address(address),
        .memWriteM(memWriteM), .memtoRegW(memtoRegW), .memSrcM(memSrcM),
        .data_in(data_in), .data_in_vec(data_in_vec),
        .data_out(data_out), .data_out_vec(data_out_vec),
        .write_done(write_done), .data_ready(data_ready), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    rd_t               rq[$];
    logic [15:0]       mem [int];
    logic [ADDR_W-1:0] addr_log[$];
    int cyc = 0, beats = 0, wr_beats = 0, rd_beats = 0;
    int wd_cnt = 0, dr_cnt = 0, dr_cyc = 0, last_rv_cyc = 0;
    bit gnt_random = 1'b0;

    int passes = 0, total = 0, st_cyc = 0;

    function automatic logic [15:0] mem_rd(input int a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    // Memory model: acts on the falling edge, so everything it drives is
    // stable for the next rising edge and every DUT output it reads is settled.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            rq.delete();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = 16'hDEAD;
        end else begin
            mem_gnt = gnt_random ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                mem_rvalid  = 1'b1;
                mem_rdata   = rq[0].data;
                last_rv_cyc = cyc;
                void'(rq.pop_front());
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = 16'hDEAD;
            end
            if (mem_req && mem_gnt) begin
                beats++;
                addr_log.push_back(mem_addr);
                if (mem_we) begin
                    mem[int'(mem_addr)] = mem_wdata;
                    wr_beats++;
                end else begin
                    rq.push_back('{cyc + 2, mem_rd(int'(mem_addr))});
                    rd_beats++;
                end
            end
        end
        if (write_done) wd_cnt++;
        if (data_ready) begin
            dr_cnt++;
            dr_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_op(input logic we, input logic rd, input logic vec,
                            input logic [31:0] a, input logic [15:0] d,
                            input logic [255:0] dv);
        memWriteM   = we;
        memtoRegW   = rd;
        memSrcM     = vec;
        address     = a;
        data_in     = d;
        data_in_vec = dv;
        st_cyc      = cyc;
    endtask

    task automatic wait_resp(output int lat);
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (write_done || data_ready) begin
                lat = cyc - st_cyc;
                break;
            end
        end
        if (lat < 0) check("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic drop();
        memWriteM = 1'b0;
        memtoRegW = 1'b0;
    endtask

    initial begin
        int lat, bad, s_wd, s_dr, s_beats, s_wr, s_rd, s_log;
        logic [255:0]      exp_vec;
        logic [255:0]      wrap_vec;
        logic [ADDR_W-1:0] ea;

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_ctrl", {mem_req, mem_we, busy, write_done, data_ready}, 5'b00000);
        check("rst_addr", mem_addr, 24'h0);
        check("rst_wdata", mem_wdata, 16'h0);
        check("rst_dout", data_out, 16'h0);
        check("rst_dvec", data_out_vec, 256'h0);

        // Scalar write, grant tied high: done two cycles after acceptance
        s_wd = wd_cnt; s_beats = beats; s_log = addr_log.size();
        start_op(1'b1, 1'b0, 1'b0, 32'h0, 16'h1001, 256'h0);
        wait_resp(lat);
        drop();
        check("sw_latency", lat, 2);
        repeat (3) tick();
        check("sw_pulses", wd_cnt - s_wd, 1);
        check("sw_beats", beats - s_beats, 1);
        check("sw_addr", addr_log[s_log], 24'h0);
        check("sw_mem", mem_rd(0), 16'h1001);
        check("sw_busy", busy, 1'b0);

        // Back-to-back vector writes: base 0 all 4, then held request base 5 all 3
        s_wd = wd_cnt; s_beats = beats; s_log = addr_log.size();
        start_op(1'b1, 1'b0, 1'b1, 32'h0, 16'h0, {16{16'h0004}});
        wait_resp(lat);
        check("vw_latency", lat, 17);
        address     = 32'd5;
        data_in_vec = {16{16'h0003}};
        wait_resp(lat);
        drop();
        repeat (3) tick();
        check("b2b_pulses", wd_cnt - s_wd, 2);
        check("b2b_beats", beats - s_beats, 32);
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            ea = (k < 16) ? 24'(k) : 24'(k - 16 + 5);
            if (addr_log[s_log + k] !== ea) bad++;
        end
        check("b2b_addrs", bad, 0);
        bad = 0;
        for (int a = 0; a <= 20; a++) begin
            if (mem_rd(a) !== ((a < 5) ? 16'h0004 : 16'h0003)) bad++;
        end
        check("b2b_mem", bad, 0);

        // Vector read of base 0 with random grant stalls
        gnt_random = 1'b1;
        s_dr = dr_cnt; s_rd = rd_beats;
        start_op(1'b0, 1'b1, 1'b1, 32'h0, 16'h0, 256'h0);
        wait_resp(lat);
        drop();
        check("vr_latency", dr_cyc, last_rv_cyc + 1);
        for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = (i < 5) ? 16'h0004 : 16'h0003;
        check("vr_vec1", data_out_vec[31:16], 16'h0004);
        check("vr_vec5", data_out_vec[95:80], 16'h0003);
        check("vr_dout", data_out, 16'h0004);
        check("vr_vec", data_out_vec, exp_vec);
        repeat (4) tick();
        check("vr_hold_vec", data_out_vec, exp_vec);
        check("vr_hold_dout", data_out, 16'h0004);
        check("vr_pulses", dr_cnt - s_dr, 1);
        check("vr_rdbeats", rd_beats - s_rd, 16);
        gnt_random = 1'b0;

        // Vector write wrapping at the top of the address space
        for (int i = 0; i < 16; i++) wrap_vec[16*i +: 16] = 16'hA000 + 16'(i);
        s_beats = beats; s_log = addr_log.size();
        start_op(1'b1, 1'b0, 1'b1, 32'hABFF_FFFD, 16'h0, wrap_vec);
        wait_resp(lat);
        drop();
        repeat (3) tick();
        check("wrap_beats", beats - s_beats, 16);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            ea = 24'hFFFFFD + 24'(k);
            if (addr_log[s_log + k] !== ea) bad++;
        end
        check("wrap_addrs", bad, 0);
        check("wrap_mem_top", mem_rd(32'hFFFFFD), 16'hA000);
        check("wrap_mem_0", mem_rd(0), 16'hA003);
        check("wrap_mem_12", mem_rd(12), 16'hA00F);

        // Write and read requested together: write wins, no read beats
        s_wd = wd_cnt; s_dr = dr_cnt; s_rd = rd_beats; s_wr = wr_beats;
        start_op(1'b1, 1'b1, 1'b0, 32'd30, 16'h0055, 256'h0);
        wait_resp(lat);
        drop();
        repeat (3) tick();
        check("both_wd", wd_cnt - s_wd, 1);
        check("both_dr", dr_cnt - s_dr, 0);
        check("both_rdbeats", rd_beats - s_rd, 0);
        check("both_wrbeats", wr_beats - s_wr, 1);
        check("both_mem", mem_rd(30), 16'h0055);

        // Scalar read: updates data_out only
        s_dr = dr_cnt;
        start_op(1'b0, 1'b1, 1'b0, 32'd30, 16'h0, 256'h0);
        wait_resp(lat);
        drop();
        repeat (2) tick();
        check("sr_dout", data_out, 16'h0055);
        check("sr_vec_kept", data_out_vec, exp_vec);
        check("sr_pulses", dr_cnt - s_dr, 1);

        // Reset after 7 vector write grants aborts without write_done
        s_wr = wr_beats; s_wd = wd_cnt;
        start_op(1'b1, 1'b0, 1'b1, 32'd100, 16'h0, {16{16'h7777}});
        for (int i = 0; i < 100; i++) begin
            tick();
            if (wr_beats - s_wr >= 7) break;
        end
        check("rm_grants", wr_beats - s_wr, 7);
        tick();
        reset = 1'b1;
        drop();
        tick();
        check("rm_ctrl", {mem_req, mem_we, busy, write_done, data_ready}, 5'b00000);
        check("rm_addr", mem_addr, 24'h0);
        check("rm_wdata", mem_wdata, 16'h0);
        check("rm_dout", data_out, 16'h0);
        check("rm_dvec", data_out_vec, 256'h0);
        reset = 1'b0;
        repeat (3) tick();
        check("rm_no_done", wd_cnt - s_wd, 0);
        check("rm_idle", {mem_req, busy}, 2'b00);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
